dram_resp_model: RTL and testbench
==================================

DRAM_RESP_MODEL -- requirements
Module: dram_resp_model

Interface
REQ-001 SHALL have parameter AW, default 10: word-address width; memory holds 2^AW words.
REQ-002 SHALL have parameter DW, default 64: data width, multiple of 8.
REQ-003 SHALL have parameter LAT, default 4, range 1-15: read latency in cycles.
REQ-004 SHALL have parameter DEPTH, default 4, power of two: maximum outstanding reads.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all state on rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port ra_rdy, input, 1: read-address request valid.
REQ-008 SHALL have port ra_ack, output, 1: read address accepted this cycle.
REQ-009 SHALL have port ra_addr, input, AW: read word address.
REQ-010 SHALL have port rd_rdy, output, 1: read data valid.
REQ-011 SHALL have port rd_ack, input, 1: read data consumed this cycle.
REQ-012 SHALL have port rd_data, output, DW: read data.
REQ-013 SHALL have port w_rdy, input, 1: write request valid.
REQ-014 SHALL have port w_ack, output, 1: write accepted this cycle.
REQ-015 SHALL have port w_addr, input, AW: write word address.
REQ-016 SHALL have port w_data, input, DW: write data.
REQ-017 SHALL have port w_mask, input, DW/8: byte enables, 1 = write byte.

Function
REQ-018 SHALL complete a transfer only in a cycle where both rdy and ack of that channel are high; ack SHALL never be high while rdy is low.
REQ-019 SHALL drive ra_ack = ra_rdy AND (outstanding count < DEPTH) AND stall gate; a pop in the same cycle SHALL NOT free a slot for a push.
REQ-020 SHALL capture memory[ra_addr] into a FIFO entry at the ra_ack cycle, together with a countdown loaded with LAT-1.
REQ-021 SHALL decrement every non-zero countdown by 1 each cycle, saturating at 0.
REQ-022 SHALL assert rd_rdy from the cycle after the head entry's countdown reaches 0, so first rd_rdy falls LAT cycles after ra_ack (ra_ack at cycle T -> rd_rdy at T+LAT).
REQ-023 SHALL hold rd_rdy and rd_data stable until rd_ack; on rd_ack it SHALL pop the head, and the next entry, if ready, SHALL present in the following cycle.
REQ-024 SHALL return read data in address-acceptance order.
REQ-025 SHALL drive w_ack = w_rdy AND stall gate; on w_ack it SHALL update only the bytes of memory[w_addr] enabled by w_mask.
REQ-026 SHALL, when a read and a write to the same address are acked in the same cycle, return the pre-write data.
REQ-027 SHALL wrap FIFO read and write pointers modulo DEPTH.
REQ-028 SHALL use a gated outstanding-count width of log2(DEPTH)+1 bits.

Reset
REQ-029 SHALL, while i_rst is high, force ra_ack=0, w_ack=0, rd_rdy=0, rd_data=0, outstanding count=0, pointers=0 and LFSR=16'hACE1, independent of i_clk.
REQ-030 SHALL discard all in-flight reads on reset and leave memory contents unchanged and not reset.
REQ-031 SHALL resume normal handshakes on the first rising edge after i_rst falls.

Configuration
REQ-032 SHALL, with macro DRAM_BACKPRESSURE_EN defined, derive the stall gate from a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle: ra gate = lfsr[0], w gate = lfsr[1].
REQ-033 SHALL, without DRAM_BACKPRESSURE_EN, hold the stall gate constantly 1 and omit the LFSR.

Verification
REQ-034 SHALL be verified by: write addr 5 data 64'h1122334455667788 mask 8'hFF, then read addr 5 with rd_ack tied high -> rd_data=64'h1122334455667788 exactly LAT cycles after ra_ack.
REQ-035 SHALL be verified by: write addr 5 mask 8'h0F data all-ones over 64'h1122334455667788, then read addr 5 -> 64'h11223344FFFFFFFF.
REQ-036 SHALL be verified by: rd_ack held low, 5 back-to-back reads issued -> exactly 4 ra_acks, ra_ack low while full; releasing rd_ack returns 4 words in order, then the fifth read is accepted.
REQ-037 SHALL be verified by: same-cycle read and write to addr 9, old data 0, new data 0xAB -> read returns 0; a later read returns 0xAB.
REQ-038 SHALL be verified by: i_rst pulsed high with 3 reads outstanding -> rd_rdy drops immediately, count=0, and no stale data appears after reset.
REQ-039 SHALL be verified by: with DRAM_BACKPRESSURE_EN defined, 1000 random reads and writes -> ra_ack/w_ack sometimes stall while rdy is high, and every rd_data matches the scoreboard.

Source files
------------

// File: rtl/dram_resp_model.sv
// Behavioural DRAM responder: byte-masked writes, fixed-latency in-order reads.
// Define DRAM_BACKPRESSURE_EN to add LFSR-driven random stalls on ra_ack/w_ack.
module dram_resp_model #(
    parameter int AW    = 10,
    parameter int DW    = 64,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          ra_rdy,
    output logic          ra_ack,
    input  logic [AW-1:0] ra_addr,
    output logic          rd_rdy,
    input  logic          rd_ack,
    output logic [DW-1:0] rd_data,
    input  logic          w_rdy,
    output logic          w_ack,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic [DW/8-1:0] w_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NB = DW / 8;

    logic [DW-1:0]              mem [2**AW];
    logic [DW-1:0]              fifo_data [DEPTH];
    logic [DEPTH-1:0][3:0]      fifo_cd;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       ra_gate;
    logic                       w_gate;
    logic                       push;
    logic                       pop;
    logic [DW-1:0]              w_merged;

`ifdef DRAM_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign ra_gate = lfsr[0];
    assign w_gate  = lfsr[1];
`else
    assign ra_gate = 1'b1;
    assign w_gate  = 1'b1;
`endif

    // Occupancy is the registered count, so a same-cycle pop never frees a slot.
    assign ra_ack  = !i_rst && ra_rdy && (count < CW'(DEPTH)) && ra_gate;
    assign w_ack   = !i_rst && w_rdy && w_gate;
    assign rd_rdy  = !i_rst && (count != '0) && (fifo_cd[rd_ptr] == 4'd0);
    assign rd_data = rd_rdy ? fifo_data[rd_ptr] : '0;
    assign push    = ra_ack;
    assign pop     = rd_rdy && rd_ack;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            fifo_cd <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr == PW'(i))) begin
                    fifo_cd[i] <= 4'(LAT - 1);
                end else if (fifo_cd[i] != 4'd0) begin
                    fifo_cd[i] <= fifo_cd[i] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_merged = mem[w_addr];
        for (int b = 0; b < NB; b++) begin
            if (w_mask[b]) begin
                w_merged[b*8 +: 8] = w_data[b*8 +: 8];
            end
        end
    end

    // Storage is never reset; the read capture sees the pre-write word on a collision.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem[ra_addr];
        end
        if (w_ack) begin
            mem[w_addr] <= w_merged;
        end
    end

endmodule

// File: tb/tb_dram_resp_model.sv
// Self-checking bench for dram_resp_model: directed scenarios plus a randomized
// run, all checked against a cycle-level queue/array reference model.
module tb_dram_resp_model;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int NB    = DW / 8;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          ra_rdy = 1'b0;
    logic          ra_ack;
    logic [AW-1:0] ra_addr = '0;
    logic          rd_rdy;
    logic          rd_ack = 1'b0;
    logic [DW-1:0] rd_data;
    logic          w_rdy = 1'b0;
    logic          w_ack;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic [NB-1:0] w_mask = '0;

    dram_resp_model #(.AW(AW), .DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .ra_rdy (ra_rdy),
        .ra_ack (ra_ack),
        .ra_addr(ra_addr),
        .rd_rdy (rd_rdy),
        .rd_ack (rd_ack),
        .rd_data(rd_data),
        .w_rdy  (w_rdy),
        .w_ack  (w_ack),
        .w_addr (w_addr),
        .w_data (w_data),
        .w_mask (w_mask)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: word array plus a queue of (data, earliest-valid cycle).
    logic [DW-1:0] mem_m [2**AW];
    logic [DW-1:0] q_data[$];
    int            q_time[$];

    logic          obs_ra_ack, obs_w_ack, obs_rd_rdy;
    logic [DW-1:0] obs_rd_data;
    logic          exp_ra_ok, exp_rd_rdy;
    logic [DW-1:0] exp_rd_data;

    // One clock cycle: sample DUT mid-cycle, form expectations, advance the model.
    task automatic do_cycle();
        logic [DW-1:0] tmp;
        @(negedge i_clk);
        obs_ra_ack  = ra_ack;
        obs_w_ack   = w_ack;
        obs_rd_rdy  = rd_rdy;
        obs_rd_data = rd_data;
        exp_ra_ok   = ra_rdy && (q_data.size() < DEPTH);
        exp_rd_rdy  = (q_data.size() > 0) && (q_time[0] <= cyc);
        exp_rd_data = exp_rd_rdy ? q_data[0] : '0;
        if (exp_rd_rdy && rd_ack) begin
            void'(q_data.pop_front());
            void'(q_time.pop_front());
        end
        if (obs_ra_ack && exp_ra_ok) begin
            q_data.push_back(mem_m[ra_addr]);
            q_time.push_back(cyc + LAT);
        end
        if (obs_w_ack && w_rdy) begin
            tmp = mem_m[w_addr];
            for (int b = 0; b < NB; b++)
                if (w_mask[b]) tmp[b*8 +: 8] = w_data[b*8 +: 8];
            mem_m[w_addr] = tmp;
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [NB-1:0] m, output bit ok);
        ok = 1'b0;
        w_rdy = 1'b1; w_addr = a; w_data = d; w_mask = m;
        for (int i = 0; i < 64 && !ok; i++) begin
            do_cycle();
            if (obs_w_ack) ok = 1'b1;
        end
        w_rdy = 1'b0;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d,
                             output int lat, output bit ok);
        int  ack_cyc;
        bit  acked;
        ok = 1'b0; acked = 1'b0; lat = -1; d = '0; ack_cyc = 0;
        ra_rdy = 1'b1; ra_addr = a; rd_ack = 1'b1;
        for (int i = 0; i < 64 && !acked; i++) begin
            ack_cyc = cyc;
            do_cycle();
            if (obs_ra_ack) acked = 1'b1;
        end
        ra_rdy = 1'b0;
        if (acked) begin
            for (int i = 0; i < 64 && !ok; i++) begin
                do_cycle();
                if (obs_rd_rdy) begin
                    ok  = 1'b1;
                    d   = obs_rd_data;
                    lat = cyc - 1 - ack_cyc;
                end
            end
        end
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        ra_rdy = 1'b1; w_rdy = 1'b1; w_mask = '1;
        #1 i_rst = 1'b1;
        #1;
        n_checks++; if (ra_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ra_ack: got %b want 0", ra_ack); end
        n_checks++; if (w_ack !== 1'b0) begin n_errors++; $display("FAIL reset_w_ack: got %b want 0", w_ack); end
        n_checks++; if (rd_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_rd_rdy: got %b want 0", rd_rdy); end
        n_checks++; if (rd_data !== '0) begin n_errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++; if (ra_ack !== 1'b0 || w_ack !== 1'b0) begin
            n_errors++; $display("FAIL reset_held_acks: got %b%b want 00", ra_ack, w_ack);
        end
        ra_rdy = 1'b0; w_rdy = 1'b0;
        i_rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_init_mem();
        bit ok;
        for (int a = 0; a < 32; a++) begin
            write_word(AW'(a), '0, '1, ok);
            n_checks++; if (!ok) begin n_errors++; $display("FAIL init_write: addr %0d got no w_ack want w_ack", a); end
        end
    endtask

    task automatic test_basic_read();
        bit ok; logic [DW-1:0] d; int lat;
        write_word(AW'(5), 64'h1122334455667788, 8'hFF, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_write: got no w_ack want w_ack"); end
        read_word(AW'(5), d, lat, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_read_timeout: got no data want data"); end
        n_checks++; if (d !== 64'h1122334455667788) begin n_errors++; $display("FAIL basic_data: got %h want 1122334455667788", d); end
        n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_mask();
        bit ok; logic [DW-1:0] d; int lat;
        write_word(AW'(5), '1, 8'h0F, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL mask_write: got no w_ack want w_ack"); end
        read_word(AW'(5), d, lat, ok);
        n_checks++; if (d !== 64'h11223344FFFFFFFF) begin n_errors++; $display("FAIL mask_data: got %h want 11223344ffffffff", d); end
        n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL mask_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_full_fifo();
        logic [DW-1:0] words [5];
        bit ok;
        int idx, acks, got, got_at_fifth;
        for (int i = 0; i < 5; i++) begin
            words[i] = {$urandom(), $urandom()};
            write_word(AW'(20 + i), words[i], '1, ok);
        end
        idx = 0; acks = 0; got = 0; got_at_fifth = -1;
        rd_ack = 1'b0; ra_rdy = 1'b1;
        for (int c = 0; c < 40; c++) begin
            ra_addr = AW'(20 + idx);
            do_cycle();
`ifdef DRAM_BACKPRESSURE_EN
            n_checks++; if (obs_ra_ack && !exp_ra_ok) begin n_errors++; $display("FAIL full_ra_ack: got 1 want 0 at cycle %0d", cyc); end
`else
            n_checks++; if (obs_ra_ack !== exp_ra_ok) begin n_errors++; $display("FAIL full_ra_ack: got %b want %b at cycle %0d", obs_ra_ack, exp_ra_ok, cyc); end
`endif
            if (obs_rd_rdy) begin
                n_checks++; if (obs_rd_data !== words[0]) begin n_errors++; $display("FAIL full_hold_data: got %h want %h", obs_rd_data, words[0]); end
            end
            if (obs_ra_ack) begin idx++; acks++; end
        end
        n_checks++; if (acks !== DEPTH) begin n_errors++; $display("FAIL full_ack_count: got %0d want %0d", acks, DEPTH); end
        n_checks++; if (obs_rd_rdy !== 1'b1) begin n_errors++; $display("FAIL full_rd_rdy_held: got %b want 1", obs_rd_rdy); end
        rd_ack = 1'b1;
        for (int c = 0; c < 100 && got < 5; c++) begin
            ra_rdy  = (idx < 5);
            ra_addr = AW'(20 + idx);
            do_cycle();
            if (obs_rd_rdy) begin
                n_checks++; if (obs_rd_data !== words[got]) begin n_errors++; $display("FAIL full_order: word %0d got %h want %h", got, obs_rd_data, words[got]); end
                got++;
            end
            if (obs_ra_ack) begin
                if (idx == 4) got_at_fifth = got;
                idx++;
            end
        end
        ra_rdy = 1'b0; rd_ack = 1'b0;
        n_checks++; if (got !== 5) begin n_errors++; $display("FAIL full_drain: got %0d words want 5", got); end
        n_checks++; if (got_at_fifth < 1) begin n_errors++; $display("FAIL full_fifth_accept: got pops-before-accept %0d want >=1", got_at_fifth); end
    endtask

    task automatic test_same_cycle();
        bit ra_done, w_done, same, ok;
        logic [DW-1:0] d; int lat;
        ra_done = 1'b0; w_done = 1'b0; same = 1'b0;
        ra_addr = AW'(9); w_addr = AW'(9); w_data = 64'hAB; w_mask = '1;
        rd_ack = 1'b0;
        for (int c = 0; c < 100 && !(ra_done && w_done); c++) begin
            ra_rdy = !ra_done; w_rdy = !w_done;
            do_cycle();
            if (obs_ra_ack && obs_w_ack) same = 1'b1;
            if (obs_ra_ack) ra_done = 1'b1;
            if (obs_w_ack) w_done = 1'b1;
        end
        ra_rdy = 1'b0; w_rdy = 1'b0;
        n_checks++; if (!(ra_done && w_done)) begin n_errors++; $display("FAIL same_acks: got ra %b w %b want 1 1", ra_done, w_done); end
`ifndef DRAM_BACKPRESSURE_EN
        n_checks++; if (!same) begin n_errors++; $display("FAIL same_cycle_ack: got separate acks want same cycle"); end
`endif
        rd_ack = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            do_cycle();
            if (obs_rd_rdy) begin
                ok = 1'b1;
                n_checks++; if (obs_rd_data !== exp_rd_data) begin n_errors++; $display("FAIL same_model: got %h want %h", obs_rd_data, exp_rd_data); end
                if (same) begin
                    n_checks++; if (obs_rd_data !== '0) begin n_errors++; $display("FAIL same_old_data: got %h want 0", obs_rd_data); end
                end
            end
        end
        rd_ack = 1'b0;
        n_checks++; if (!ok) begin n_errors++; $display("FAIL same_read_timeout: got no data want data"); end
        read_word(AW'(9), d, lat, ok);
        n_checks++; if (d !== 64'hAB) begin n_errors++; $display("FAIL same_new_data: got %h want ab", d); end
    endtask

    task automatic test_reset_inflight();
        int acks, seen;
        bit found;
        rd_ack = 1'b0; ra_rdy = 1'b1; acks = 0;
        for (int c = 0; c < 60 && acks < 3; c++) begin
            ra_addr = AW'(1 + acks);
            do_cycle();
            if (obs_ra_ack) acks++;
        end
        ra_rdy = 1'b0;
        found = 1'b0;
        for (int c = 0; c < LAT + 4 && !found; c++) begin
            do_cycle();
            if (obs_rd_rdy) found = 1'b1;
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL inflight_pre_rdy: got 0 want 1"); end
        ra_rdy = 1'b1;
        i_rst = 1'b1;
        #1;
        n_checks++; if (rd_rdy !== 1'b0) begin n_errors++; $display("FAIL inflight_rd_rdy_drop: got %b want 0", rd_rdy); end
        n_checks++; if (rd_data !== '0) begin n_errors++; $display("FAIL inflight_rd_data: got %h want 0", rd_data); end
        n_checks++; if (ra_ack !== 1'b0) begin n_errors++; $display("FAIL inflight_ra_ack: got %b want 0", ra_ack); end
        q_data.delete();
        q_time.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0; ra_rdy = 1'b0;
        cyc++;
        seen = 0;
        for (int c = 0; c < 2 * LAT + 2; c++) begin
            do_cycle();
            if (obs_rd_rdy) seen++;
        end
        n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL inflight_stale: got %0d rd_rdy cycles want 0", seen); end
        acks = 0; ra_rdy = 1'b1;
        for (int c = 0; c < 60; c++) begin
            ra_addr = AW'(c % 16);
            do_cycle();
            if (obs_ra_ack) acks++;
        end
        ra_rdy = 1'b0;
        n_checks++; if (acks !== DEPTH) begin n_errors++; $display("FAIL inflight_count_cleared: got %0d acks want %0d", acks, DEPTH); end
        rd_ack = 1'b1;
        for (int c = 0; c < 40; c++) begin
            do_cycle();
            if (exp_rd_rdy || obs_rd_rdy) begin
                n_checks++; if (obs_rd_data !== exp_rd_data) begin n_errors++; $display("FAIL inflight_drain: got %h want %h", obs_rd_data, exp_rd_data); end
            end
        end
        rd_ack = 1'b0;
    endtask

    task automatic test_random();
        int ra_stalls, w_stalls;
        ra_stalls = 0; w_stalls = 0;
        for (int c = 0; c < 1100; c++) begin
            if (c < 1000) begin
                ra_rdy  = ($urandom_range(0, 1) == 1);
                ra_addr = AW'($urandom_range(0, 15));
                w_rdy   = ($urandom_range(0, 1) == 1);
                w_addr  = AW'($urandom_range(0, 15));
                w_data  = {$urandom(), $urandom()};
                w_mask  = NB'($urandom());
                rd_ack  = ($urandom_range(0, 3) != 0);
            end else begin
                ra_rdy = 1'b0; w_rdy = 1'b0; rd_ack = 1'b1;
            end
            do_cycle();
            n_checks++; if (obs_rd_rdy !== exp_rd_rdy) begin n_errors++; $display("FAIL rand_rd_rdy: cycle %0d got %b want %b", cyc, obs_rd_rdy, exp_rd_rdy); end
            if (exp_rd_rdy) begin
                n_checks++; if (obs_rd_data !== exp_rd_data) begin n_errors++; $display("FAIL rand_rd_data: cycle %0d got %h want %h", cyc, obs_rd_data, exp_rd_data); end
            end
`ifdef DRAM_BACKPRESSURE_EN
            n_checks++; if (obs_ra_ack && !exp_ra_ok) begin n_errors++; $display("FAIL rand_ra_ack: cycle %0d got 1 want 0", cyc); end
            n_checks++; if (obs_w_ack && !w_rdy) begin n_errors++; $display("FAIL rand_w_ack: cycle %0d got 1 want 0", cyc); end
`else
            n_checks++; if (obs_ra_ack !== exp_ra_ok) begin n_errors++; $display("FAIL rand_ra_ack: cycle %0d got %b want %b", cyc, obs_ra_ack, exp_ra_ok); end
            n_checks++; if (obs_w_ack !== w_rdy) begin n_errors++; $display("FAIL rand_w_ack: cycle %0d got %b want %b", cyc, obs_w_ack, w_rdy); end
`endif
            if (exp_ra_ok && !obs_ra_ack) ra_stalls++;
            if (w_rdy && !obs_w_ack) w_stalls++;
        end
        rd_ack = 1'b0;
`ifdef DRAM_BACKPRESSURE_EN
        n_checks++; if (ra_stalls == 0 || w_stalls == 0) begin n_errors++; $display("FAIL rand_stalls: got ra %0d w %0d want both >0", ra_stalls, w_stalls); end
`else
        n_checks++; if (ra_stalls != 0 || w_stalls != 0) begin n_errors++; $display("FAIL rand_stalls: got ra %0d w %0d want 0 0", ra_stalls, w_stalls); end
`endif
        n_checks++; if (q_data.size() != 0) begin n_errors++; $display("FAIL rand_drain: got %0d left want 0", q_data.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init_mem();
        test_basic_read();
        test_mask();
        test_full_fifo();
        test_same_cycle();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
